spectrum_st_sink: RTL and testbench

- Avalon-ST sink for the 32-bit spectrum packet stream (data/valid/ready/sop/eop/empty) that the acquisition chain sends toward NIOS.
- Captures each packet into one of two ping-pong frame banks and checks its framing and length.
- The CPU reads a completed bank through a simple 1-cycle-latency read port, then releases it.
- Sits on the NIOS side; the only clock is nios_clk.

---
 rtl/spectrum_st_pkg.sv | 17 +
 rtl/frame_ram.sv | 28 ++
 rtl/spectrum_st_sink.sv | 171 +++++++++++++++++
 tb/tb_spectrum_st_sink.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_st_pkg.sv
// Shared types and constants for the spectrum packet sink.
// State encoding, error flag positions and default frame geometry.
package spectrum_st_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } st_state_t;

    localparam int ERR_SHORT = 0;
    localparam int ERR_LONG  = 1;

    localparam int DEF_FRAME_WORDS = 1024;
    localparam int DEF_ADDR_W      = 10;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Address is {bank, word}; the output register is the only reset state.
module frame_ram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/spectrum_st_sink.sv
// Avalon-ST spectrum sink: captures packets into ping-pong frame banks
// with framing/length checks and a CPU read/release port.
module spectrum_st_sink
    import spectrum_st_pkg::*;
#(
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              nios_clk,
    input  logic              reset_n,
    input  logic [31:0]       st_data,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic              st_sop,
    input  logic              st_eop,
    input  logic [1:0]        st_empty,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic [31:0]       rd_data,
    output logic              frame_avail,
    output logic [ADDR_W:0]   frame_len,
    output logic [1:0]        frame_empty,
    output logic [1:0]        frame_err,
    input  logic              frame_release,
    output logic [15:0]       drop_cnt
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(FRAME_WORDS);

    st_state_t         state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt, wr_word;
    logic [1:0]        bank_full, set_full, clr_full;
    logic              wr_bank, rd_bank;
    logic [LEN_W-1:0]  len_q [2];
    logic [1:0]        empty_q [2];
    logic [1:0]        err_q [2];

    logic              beat, wr_en, done, done_long, drop_inc, rel_ok;
    logic [LEN_W-1:0]  done_len;
    logic [1:0]        err_v;

    assign st_ready    = ~bank_full[wr_bank] | (state == DROP);
    assign beat        = st_valid & st_ready;
    assign frame_avail = |bank_full;
    assign rel_ok      = frame_release & frame_avail;
    assign frame_len   = len_q[rd_bank];
    assign frame_empty = empty_q[rd_bank];
    assign frame_err   = err_q[rd_bank];

    // Completion targets wr_bank (always FREE), release targets rd_bank
    // (always FULL), so the two masks never overlap.
    assign set_full = {done & wr_bank, done & ~wr_bank};
    assign clr_full = {rel_ok & rd_bank, rel_ok & ~rd_bank};

    always_ff @(posedge nios_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (beat && st_sop && !st_eop) state_nxt = RECV;
            RECV: if (beat) begin
                if (st_eop)                      state_nxt = IDLE;
                else if (!st_sop && addr == LAST) state_nxt = DROP;
            end
            DROP: if (beat && st_eop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_word   = '0;
        done      = 1'b0;
        done_long = 1'b0;
        done_len  = '0;
        drop_inc  = 1'b0;
        addr_nxt  = addr;
        unique case (state)
            IDLE: if (beat) begin
                if (st_sop) begin
                    wr_en = 1'b1;
                    if (st_eop) begin
                        done     = 1'b1;
                        done_len = LEN_W'(1);
                    end else begin
                        addr_nxt = ADDR_W'(1);
                    end
                end else begin
                    drop_inc = 1'b1;
                end
            end
            RECV: if (beat) begin
                wr_en = 1'b1;
                if (st_sop) begin
                    if (st_eop) begin
                        done     = 1'b1;
                        done_len = LEN_W'(1);
                        addr_nxt = '0;
                    end else begin
                        addr_nxt = ADDR_W'(1);
                    end
                end else begin
                    wr_word = addr;
                    if (st_eop || addr == LAST) begin
                        done      = 1'b1;
                        done_long = ~st_eop;
                        done_len  = LEN_W'(addr) + LEN_W'(1);
                        addr_nxt  = '0;
                    end else begin
                        addr_nxt = addr + ADDR_W'(1);
                    end
                end
            end
            DROP: drop_inc = beat;
            default: ;
        endcase
    end

    always_comb begin
        err_v            = '0;
        err_v[ERR_SHORT] = done_len < FULL_LEN;
        err_v[ERR_LONG]  = done_long;
    end

    always_ff @(posedge nios_clk or negedge reset_n) begin
        if (!reset_n) begin
            addr       <= '0;
            bank_full  <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            empty_q[0] <= '0;
            empty_q[1] <= '0;
            err_q[0]   <= '0;
            err_q[1]   <= '0;
            drop_cnt   <= '0;
        end else begin
            addr      <= addr_nxt;
            bank_full <= (bank_full | set_full) & ~clr_full;
            if (done) begin
                len_q[wr_bank]   <= done_len;
                empty_q[wr_bank] <= done_long ? 2'b00 : st_empty;
                err_q[wr_bank]   <= err_v;
                wr_bank          <= ~wr_bank;
            end
            if (rel_ok) rd_bank <= ~rd_bank;
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    frame_ram #(
        .AW(LEN_W),
        .DW(32)
    ) u_ram (
        .clk  (nios_clk),
        .rst_n(reset_n),
        .we   (wr_en),
        .waddr({wr_bank, wr_word}),
        .wdata(st_data),
        .re   (rd_en),
        .raddr({rd_bank, rd_addr}),
        .rdata(rd_data)
    );

endmodule

// File: tb/tb_spectrum_st_sink.sv
// Self-checking bench for spectrum_st_sink against a packet-level
// reference model (queue of completed frames, drop counter).
module tb_spectrum_st_sink;

    localparam int FW = 1024;
    localparam int AW = 10;

    logic          nios_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   st_data = '0;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic          st_sop = 1'b0;
    logic          st_eop = 1'b0;
    logic [1:0]    st_empty = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_en = 1'b0;
    logic [31:0]   rd_data;
    logic          frame_avail;
    logic [AW:0]   frame_len;
    logic [1:0]    frame_empty;
    logic [1:0]    frame_err;
    logic          frame_release = 1'b0;
    logic [15:0]   drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    spectrum_st_sink #(.FRAME_WORDS(FW), .ADDR_W(AW)) dut (
        .nios_clk     (nios_clk),
        .reset_n      (reset_n),
        .st_data      (st_data),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_sop       (st_sop),
        .st_eop       (st_eop),
        .st_empty     (st_empty),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .frame_avail  (frame_avail),
        .frame_len    (frame_len),
        .frame_empty  (frame_empty),
        .frame_err    (frame_err),
        .frame_release(frame_release),
        .drop_cnt     (drop_cnt)
    );

    always #5 nios_clk = ~nios_clk;

    // Reference model: completed frames in arrival order, packet in flight.
    typedef struct {
        logic [31:0] w [FW];
        int          len;
        logic [1:0]  empty;
        logic [1:0]  err;
    } frame_t;

    frame_t      frames[$];
    frame_t      cur;
    int          cur_n = 0;
    bit          m_inpkt = 0;
    bit          m_dropping = 0;
    logic [15:0] m_drop = '0;

    function automatic void m_reset();
        frames.delete();
        cur_n = 0;
        m_inpkt = 0;
        m_dropping = 0;
        m_drop = '0;
    endfunction

    function automatic void m_count_drop();
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    endfunction

    function automatic void m_done(logic [1:0] em, bit long_pkt);
        cur.len = cur_n;
        cur.empty = long_pkt ? 2'b00 : em;
        cur.err = {long_pkt, (cur_n < FW) ? 1'b1 : 1'b0};
        frames.push_back(cur);
        m_inpkt = 0;
        cur_n = 0;
    endfunction

    function automatic void m_beat(logic [31:0] d, logic s, logic e, logic [1:0] em);
        if (m_dropping) begin
            m_count_drop();
            if (e) m_dropping = 0;
        end else if (s) begin
            cur.w[0] = d;
            cur_n = 1;
            m_inpkt = 1;
            if (e) m_done(em, 0);
        end else if (!m_inpkt) begin
            m_count_drop();
        end else begin
            cur.w[cur_n] = d;
            cur_n++;
            if (e) m_done(em, 0);
            else if (cur_n == FW) begin
                m_done(2'b00, 1);
                m_dropping = 1;
            end
        end
    endfunction

    function automatic logic [15:0] exp_status();
        if (frames.size() == 0) return '0;
        return {1'b1, 11'(frames[0].len), frames[0].empty, frames[0].err};
    endfunction

    // Stimulus tasks: called at a negedge, return at a negedge.
    task automatic send(input logic [31:0] d, input logic s, input logic e,
                        input logic [1:0] em);
        int w = 0;
        st_data = d;
        st_sop = s;
        st_eop = e;
        st_empty = em;
        st_valid = 1'b1;
        while (!st_ready && w < 3000) begin
            @(negedge nios_clk);
            w++;
        end
        if (!st_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: st_ready=%b after %0d cycles, required 1",
                     st_ready, w);
        end else begin
            @(negedge nios_clk);
            m_beat(d, s, e, em);
        end
        st_valid = 1'b0;
        st_sop = 1'b0;
        st_eop = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit with_sop, input logic [1:0] em,
                            input bit idx_data);
        for (int i = 0; i < n; i++)
            send(idx_data ? 32'(i) : $urandom, with_sop && i == 0, i == n - 1,
                 (i == n - 1) ? em : 2'b00);
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        rd_addr = AW'(a);
        rd_en = 1'b1;
        @(negedge nios_clk);
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic rel();
        frame_release = 1'b1;
        @(negedge nios_clk);
        frame_release = 1'b0;
        if (frames.size() > 0) void'(frames.pop_front());
    endtask

    task automatic test_reset();
        logic [15:0] st;
        reset_n = 1'b0;
        m_reset();
        repeat (3) @(negedge nios_clk);
        st = {frame_avail, frame_len, frame_empty, frame_err};
        vectors++;
        if (st !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_status: got %h required 0000", st);
        end
        vectors++;
        if (drop_cnt !== 16'h0 || rd_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_counters: drop=%h rd=%h required 0", drop_cnt, rd_data);
        end
        reset_n = 1'b1;
        @(negedge nios_clk);
        vectors++;
        if (st_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b required 1", st_ready);
        end
    endtask

    task automatic test_full_packet();
        logic [31:0] d;
        send_pkt(FW, 1, 2'b00, 1);
        vectors++;
        if ({frame_avail, frame_len, frame_empty, frame_err} !== exp_status()) begin
            miscompares++;
            $display("FAIL full_status: got %h required %h",
                     {frame_avail, frame_len, frame_empty, frame_err}, exp_status());
        end
        for (int i = 0; i < FW; i++) begin
            rd(i, d);
            vectors++;
            if (d !== frames[0].w[i]) begin
                miscompares++;
                $display("FAIL full_read[%0d]: got %h required %h", i, d, frames[0].w[i]);
            end
        end
        repeat (2) @(negedge nios_clk);
        vectors++;
        if (rd_data !== frames[0].w[FW-1]) begin
            miscompares++;
            $display("FAIL rd_hold: got %h required %h", rd_data, frames[0].w[FW-1]);
        end
        rel();
    endtask

    task automatic test_short_packet();
        send_pkt(10, 1, 2'b10, 0);
        vectors++;
        if ({frame_avail, frame_len, frame_empty, frame_err} !== exp_status()) begin
            miscompares++;
            $display("FAIL short_status: got %h required %h",
                     {frame_avail, frame_len, frame_empty, frame_err}, exp_status());
        end
        rel();
        vectors++;
        if (frame_avail !== 1'b0) begin
            miscompares++;
            $display("FAIL short_release: avail=%b required 0", frame_avail);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, d0;
        int a;
        send_pkt(FW, 1, 2'b00, 0);
        send_pkt(FW, 1, 2'b00, 0);
        d0 = $urandom;
        st_data = d0;
        st_sop = 1'b1;
        st_eop = 1'b0;
        st_empty = 2'b00;
        st_valid = 1'b1;
        repeat (3) @(negedge nios_clk);
        vectors++;
        if (st_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pp_stall: st_ready=%b required 0", st_ready);
        end
        frame_release = 1'b1;
        @(negedge nios_clk);
        frame_release = 1'b0;
        void'(frames.pop_front());
        vectors++;
        if (st_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL pp_resume: st_ready=%b required 1", st_ready);
        end
        @(negedge nios_clk);
        m_beat(d0, 1, 0, 2'b00);
        st_valid = 1'b0;
        st_sop = 1'b0;
        for (int i = 1; i < FW; i++) send($urandom, 0, i == FW - 1, 2'b00);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({frame_avail, frame_len, frame_empty, frame_err} !== exp_status()) begin
                miscompares++;
                $display("FAIL pp_status[%0d]: got %h required %h", k,
                         {frame_avail, frame_len, frame_empty, frame_err}, exp_status());
            end
            for (int j = 0; j < 6; j++) begin
                a = (j == 0) ? 0 : $urandom_range(1, FW - 1);
                rd(a, d);
                vectors++;
                if (d !== frames[0].w[a]) begin
                    miscompares++;
                    $display("FAIL pp_read[%0d][%0d]: got %h required %h", k, a, d,
                             frames[0].w[a]);
                end
            end
            rel();
        end
        vectors++;
        if (frame_avail !== 1'b0) begin
            miscompares++;
            $display("FAIL pp_drained: avail=%b required 0", frame_avail);
        end
    endtask

    task automatic test_framing();
        logic [31:0] d;
        for (int i = 0; i < 5; i++) send($urandom, 0, 0, 2'b00);
        vectors++;
        if (drop_cnt !== m_drop || frame_avail !== 1'b0) begin
            miscompares++;
            $display("FAIL nosop_drop: drop=%0d avail=%b required drop=%0d avail=0",
                     drop_cnt, frame_avail, m_drop);
        end
        send($urandom, 1, 0, 2'b00);
        for (int i = 0; i < 3; i++) send($urandom, 0, 0, 2'b00);
        send($urandom, 1, 0, 2'b00);
        for (int i = 0; i < 4; i++) send($urandom, 0, i == 3, 2'b01);
        vectors++;
        if ({frame_avail, frame_len, frame_empty, frame_err} !== exp_status()
            || drop_cnt !== m_drop) begin
            miscompares++;
            $display("FAIL restart_status: got %h drop=%0d required %h drop=%0d",
                     {frame_avail, frame_len, frame_empty, frame_err}, drop_cnt,
                     exp_status(), m_drop);
        end
        for (int i = 0; i < 5; i++) begin
            rd(i, d);
            vectors++;
            if (d !== frames[0].w[i]) begin
                miscompares++;
                $display("FAIL restart_read[%0d]: got %h required %h", i, d, frames[0].w[i]);
            end
        end
        rel();
    endtask

    task automatic test_overlong();
        logic [31:0] d;
        send_pkt(FW + 6, 1, 2'b11, 0);
        vectors++;
        if ({frame_avail, frame_len, frame_empty, frame_err} !== exp_status()
            || drop_cnt !== m_drop) begin
            miscompares++;
            $display("FAIL long_status: got %h drop=%0d required %h drop=%0d",
                     {frame_avail, frame_len, frame_empty, frame_err}, drop_cnt,
                     exp_status(), m_drop);
        end
        rd(FW - 1, d);
        vectors++;
        if (d !== frames[0].w[FW-1]) begin
            miscompares++;
            $display("FAIL long_read_last: got %h required %h", d, frames[0].w[FW-1]);
        end
        rel();
        send_pkt(7, 1, 2'b11, 0);
        vectors++;
        if ({frame_avail, frame_len, frame_empty, frame_err} !== exp_status()) begin
            miscompares++;
            $display("FAIL after_long_status: got %h required %h",
                     {frame_avail, frame_len, frame_empty, frame_err}, exp_status());
        end
        rd(6, d);
        vectors++;
        if (d !== frames[0].w[6]) begin
            miscompares++;
            $display("FAIL after_long_read: got %h required %h", d, frames[0].w[6]);
        end
        rel();
    endtask

    task automatic test_simultaneous();
        logic [31:0] d, dl;
        send_pkt(20, 1, 2'b00, 0);
        for (int i = 0; i < 11; i++) send($urandom, i == 0, 0, 2'b00);
        dl = $urandom;
        st_data = dl;
        st_sop = 1'b0;
        st_eop = 1'b1;
        st_empty = 2'b01;
        st_valid = 1'b1;
        frame_release = 1'b1;
        @(negedge nios_clk);
        st_valid = 1'b0;
        st_eop = 1'b0;
        frame_release = 1'b0;
        void'(frames.pop_front());
        m_beat(dl, 0, 1, 2'b01);
        vectors++;
        if ({frame_avail, frame_len, frame_empty, frame_err} !== exp_status()) begin
            miscompares++;
            $display("FAIL simul_status: got %h required %h",
                     {frame_avail, frame_len, frame_empty, frame_err}, exp_status());
        end
        rd(11, d);
        vectors++;
        if (d !== frames[0].w[11]) begin
            miscompares++;
            $display("FAIL simul_read: got %h required %h", d, frames[0].w[11]);
        end
        rel();
        vectors++;
        if (frame_avail !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_drained: avail=%b required 0", frame_avail);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [31:0] d;
        send_pkt(30, 1, 2'b00, 0);
        for (int i = 0; i < 500; i++) send($urandom, i == 0, 0, 2'b00);
        #2 reset_n = 1'b0;
        m_reset();
        #1;
        vectors++;
        if (frame_avail !== 1'b0 || drop_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL midrst_async: avail=%b drop=%h required 0/0", frame_avail, drop_cnt);
        end
        @(negedge nios_clk);
        reset_n = 1'b1;
        @(negedge nios_clk);
        vectors++;
        if (st_ready !== 1'b1 || {frame_avail, frame_len, frame_empty, frame_err} !== 16'h0) begin
            miscompares++;
            $display("FAIL midrst_state: ready=%b status=%h required 1/0000", st_ready,
                     {frame_avail, frame_len, frame_empty, frame_err});
        end
        send_pkt(3, 1, 2'b10, 0);
        vectors++;
        if ({frame_avail, frame_len, frame_empty, frame_err} !== exp_status()) begin
            miscompares++;
            $display("FAIL midrst_capture: got %h required %h",
                     {frame_avail, frame_len, frame_empty, frame_err}, exp_status());
        end
        for (int i = 0; i < 3; i++) begin
            rd(i, d);
            vectors++;
            if (d !== frames[0].w[i]) begin
                miscompares++;
                $display("FAIL midrst_read[%0d]: got %h required %h", i, d, frames[0].w[i]);
            end
        end
        rel();
    endtask

    task automatic test_random();
        logic [31:0] d;
        int op, n, a;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 4);
            if (op != 2 && frames.size() == 2 && !m_dropping) rel();
            case (op)
                0, 1, 4: begin
                    n = $urandom_range(1, 40);
                    for (int i = 0; i < n; i++) begin
                        repeat ($urandom_range(0, 2)) @(negedge nios_clk);
                        send($urandom, i == 0 && $urandom_range(0, 7) != 0,
                             i == n - 1, 2'($urandom));
                    end
                end
                2: rel();
                default: for (int i = 0; i < $urandom_range(1, 3); i++)
                    send($urandom, 0, 0, 2'b00);
            endcase
            vectors++;
            if (frame_avail !== (frames.size() > 0) || drop_cnt !== m_drop) begin
                miscompares++;
                $display("FAIL rand_avail[%0d]: avail=%b drop=%0d required %b/%0d", it,
                         frame_avail, drop_cnt, frames.size() > 0, m_drop);
            end
            if (frames.size() > 0) begin
                vectors++;
                if ({frame_avail, frame_len, frame_empty, frame_err} !== exp_status()) begin
                    miscompares++;
                    $display("FAIL rand_status[%0d]: got %h required %h", it,
                             {frame_avail, frame_len, frame_empty, frame_err}, exp_status());
                end
                a = $urandom_range(0, frames[0].len - 1);
                rd(a, d);
                vectors++;
                if (d !== frames[0].w[a]) begin
                    miscompares++;
                    $display("FAIL rand_read[%0d]: addr %0d got %h required %h", it, a, d,
                             frames[0].w[a]);
                end
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge nios_clk);
        test_reset();
        test_full_packet();
        test_short_packet();
        test_back_to_back();
        test_framing();
        test_overlong();
        test_simultaneous();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
